// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg
// Shared decode vocabulary for the D-stage stall controller and its
// mult/div busy counter. It holds the instruction field ranges, the opcode and
// funct constants, the NOP encoding, the Tuse/Tnew timing encoding, and small
// helper functions that classify an instruction and test one source operand
// for a hazard.
// No ports (package only).

package hazard_stall_ctrl_pkg;

    // Instruction field ranges
    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;

    // sll $0,$0,0 -- the canonical bubble
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Opcodes
    localparam logic [5:0] OP_SPECIAL   = 6'h00;
    localparam logic [5:0] OP_REGIMM    = 6'h01;
    localparam logic [5:0] OP_JAL       = 6'h03;
    localparam logic [5:0] OP_BEQ       = 6'h04;
    localparam logic [5:0] OP_BNE       = 6'h05;
    localparam logic [5:0] OP_BGTZ      = 6'h07;
    localparam logic [5:0] OP_CALI_MIN  = 6'h08;
    localparam logic [5:0] OP_CALI_MAX  = 6'h0F;
    localparam logic [5:0] OP_LOAD_MIN  = 6'h20;
    localparam logic [5:0] OP_LOAD_MAX  = 6'h25;
    localparam logic [5:0] OP_STORE_MIN = 6'h28;
    localparam logic [5:0] OP_STORE_MAX = 6'h2B;

    // SPECIAL funct codes
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    // Cycles until a value is needed (Tuse) or produced (Tnew). T_NONE marks
    // "operand not read" and compares greater than any real Tnew, so it can
    // never trigger a stall.
    typedef enum logic [1:0] {
        T_ZERO = 2'd0,
        T_ONE  = 2'd1,
        T_TWO  = 2'd2,
        T_NONE = 2'd3
    } timing_e;

    typedef struct packed {
        logic calR;
        logic calI;
        logic load;
        logic store;
        logic branch;
        logic beqBne;
        logic jr;
        logic jalr;
        logic jal;
        logic mdOp;
        logic hiloOp;
        logic mfHiLo;
    } instrClass_t;

    // mult/multu/div/divu: the instructions that occupy the HI/LO unit
    function automatic logic isMdOp(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_SPECIAL) && (funct >= FN_MULT) && (funct <= FN_DIVU);
    endfunction

    function automatic instrClass_t classifyInstr(input logic [5:0] op, input logic [5:0] funct);
        instrClass_t cls;
        logic        special;
        logic        mtHiLo;
        special      = (op == OP_SPECIAL);
        mtHiLo       = special && ((funct == FN_MTHI) || (funct == FN_MTLO));
        cls          = '0;
        cls.mdOp     = isMdOp(op, funct);
        cls.jr       = special && (funct == FN_JR);
        cls.jalr     = special && (funct == FN_JALR);
        cls.mfHiLo   = special && ((funct == FN_MFHI) || (funct == FN_MFLO));
        cls.hiloOp   = (special && (funct >= FN_MFHI) && (funct <= FN_MTLO)) || cls.mdOp;
        cls.calR     = special && !cls.jr && !cls.jalr && !cls.mdOp && !mtHiLo;
        cls.calI     = (op >= OP_CALI_MIN) && (op <= OP_CALI_MAX);
        cls.load     = (op >= OP_LOAD_MIN) && (op <= OP_LOAD_MAX);
        cls.store    = (op >= OP_STORE_MIN) && (op <= OP_STORE_MAX);
        cls.branch   = (op == OP_REGIMM) || ((op >= OP_BEQ) && (op <= OP_BGTZ));
        cls.beqBne   = (op == OP_BEQ) || (op == OP_BNE);
        cls.jal      = (op == OP_JAL);
        return cls;
    endfunction

    // Register written by an instruction; $0 doubles as "no destination"
    function automatic logic [4:0] destReg(input logic useRd, input logic useRt,
                                           input logic link, input logic [4:0] rt,
                                           input logic [4:0] rd);
        if (useRd)     return rd;
        else if (useRt) return rt;
        else if (link)  return REG_RA;
        else            return REG_ZERO;
    endfunction

    // One source operand stalls when its producer in E or M cannot deliver
    // the value by the time D-stage consumer needs it.
    function automatic logic srcHazard(input logic [4:0] src, input timing_e tUse,
                                       input logic [4:0] destE, input timing_e tNewE,
                                       input logic [4:0] destM, input timing_e tNewM);
        return (src != REG_ZERO) &&
               (((src == destE) && (tUse < tNewE)) ||
                ((src == destM) && (tUse < tNewM)));
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_cnt.sv
// md_busy_cnt
// Busy tracker for the multi-cycle mult/div unit. A mult/div entering E
// loads the remaining-cycle counter; the unit reports busy during the start
// cycle and while the counter is non-zero, giving exactly LAT busy cycles.
// Ports:
//   clk_i      clock, rising edge
//   rst_n_i    synchronous active-low reset (also masks mdBusy_o)
//   opE_i      opcode of the instruction in E
//   functE_i   funct of the instruction in E
//   mdBusy_o   HI/LO unit occupied

module md_busy_cnt
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [5:0] opE_i,
    input  logic [5:0] functE_i,
    output logic       mdBusy_o
);

    logic             start;
    logic             isDiv;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next-count logic. The start cycle itself counts as the first busy
    // cycle, so the counter is loaded with LAT-1. A start while still busy
    // simply reloads (restart), though the stall logic should prevent that.
    always_comb begin
        start = isMdOp(opE_i, functE_i);
        isDiv = (functE_i == FN_DIV) || (functE_i == FN_DIVU);
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = isDiv ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register; reset abandons any operation in flight
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mdBusy_o = rst_n_i & (start | (cnt_q != '0));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// D-stage stall/flush control for the 5-stage MIPS pipeline. Handles the
// hazards forwarding cannot fix: the producer in E or M will not have its
// result ready before the D-stage instruction needs it (Tuse < Tnew), and
// HI/LO consumers arriving while the mult/div unit is still busy.
// On a stall, PC and IF/ID hold and ID/EX is loaded with a bubble.
// Optional build macro: STALL_PERF_CNT_EN adds a 32-bit stall-cycle counter.
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset; outputs are forced 0 while low
//   IR_D       instruction in ID
//   IR_E       instruction in EX
//   IR_M       instruction in MEM
//   Stall      freeze PC and IF/ID
//   Flush_E    load NOP into ID/EX next edge (same as Stall)
//   md_busy    mult/div unit occupied
//   stall_cnt  stall-cycle count (STALL_PERF_CNT_EN only)

module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IR_D,
    input  logic [31:0] IR_E,
    input  logic [31:0] IR_M,
    output logic        Stall,
    output logic        Flush_E,
    output logic        md_busy
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    instrClass_t clsD;
    instrClass_t clsE;
    instrClass_t clsM;
    logic [4:0]  rsD;
    logic [4:0]  rtD;
    logic [4:0]  destE;
    logic [4:0]  destM;
    timing_e     tUseRs;
    timing_e     tUseRt;
    timing_e     tNewE;
    timing_e     tNewM;
    logic        regStall;
    logic        mdStall;
    logic        mdBusyInt;
    logic        unusedOk;

    assign clsD = classifyInstr(IR_D[OP_HI:OP_LO], IR_D[FUNCT_HI:FUNCT_LO]);
    assign clsE = classifyInstr(IR_E[OP_HI:OP_LO], IR_E[FUNCT_HI:FUNCT_LO]);
    assign clsM = classifyInstr(IR_M[OP_HI:OP_LO], IR_M[FUNCT_HI:FUNCT_LO]);
    assign rsD  = IR_D[RS_HI:RS_LO];
    assign rtD  = IR_D[RT_HI:RT_LO];

    assign destE = destReg(clsE.calR | clsE.jalr, clsE.calI | clsE.load, clsE.jal,
                           IR_E[RT_HI:RT_LO], IR_E[RD_HI:RD_LO]);
    assign destM = destReg(clsM.calR | clsM.jalr, clsM.calI | clsM.load, clsM.jal,
                           IR_M[RT_HI:RT_LO], IR_M[RD_HI:RD_LO]);

    // Fields and class bits this block has no use for (shamt, immediates,
    // D's own destination, E/M sources)
    assign unusedOk = ^{IR_D[15:6], IR_E[25:21], IR_E[10:6], IR_M[25:21], IR_M[10:6],
                        clsD, clsE, clsM};

    // Tuse for the D-stage operands. Branches and jump-registers compare in D
    // and need the value immediately; stores only need rt at the memory
    // stage; mfhi/mflo read no GPR through rt.
    always_comb begin
        tUseRs = T_NONE;
        if (clsD.branch || clsD.jr || clsD.jalr) begin
            tUseRs = T_ZERO;
        end else if (clsD.calR || clsD.calI || clsD.load || clsD.store) begin
            tUseRs = T_ONE;
        end

        tUseRt = T_NONE;
        if (clsD.beqBne) begin
            tUseRt = T_ZERO;
        end else if (clsD.calR && !clsD.mfHiLo) begin
            tUseRt = T_ONE;
        end else if (clsD.store) begin
            tUseRt = T_TWO;
        end
    end

    // Tnew of the producers still ahead in the pipe. Link writes (jal/jalr)
    // are available for forwarding from E onwards, so they never stall.
    always_comb begin
        tNewE = T_ZERO;
        if (clsE.load) begin
            tNewE = T_TWO;
        end else if (clsE.calR || clsE.calI) begin
            tNewE = T_ONE;
        end

        tNewM = clsM.load ? T_ONE : T_ZERO;
    end

    md_busy_cnt #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) uMdBusy (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .opE_i    (IR_E[OP_HI:OP_LO]),
        .functE_i (IR_E[FUNCT_HI:FUNCT_LO]),
        .mdBusy_o (mdBusyInt)
    );

    // Stall combines register hazards with HI/LO-unit occupancy; reset masks
    // it so nothing freezes while the pipe is being cleared.
    always_comb begin
        regStall = srcHazard(rsD, tUseRs, destE, tNewE, destM, tNewM) |
                   srcHazard(rtD, tUseRt, destE, tNewE, destM, tNewM);
        mdStall  = clsD.hiloOp & mdBusyInt;
        Stall    = rst_n & (regStall | mdStall);
    end

    assign Flush_E = Stall;
    assign md_busy = mdBusyInt;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stallCnt_d;
    logic [31:0] stallCnt_q;

    // Stall-cycle counter, free-running and wrapping at 2^32
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (Stall) begin
            stallCnt_d = stallCnt_q + 32'd1;
        end
    end

    // Stall-cycle counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stall_cnt = stallCnt_q;
`else
    // No performance counter in this build
`endif

endmodule
